// File: rtl/pb_keycode_encoder.sv
// Synchronised, debounced pushbutton bank to a one-shot binary keycode strobe (highest index wins).
// Optional auto-repeat while the key is held: build with PB_ENC_AUTOREPEAT_EN defined.
module pb_keycode_encoder #(
    parameter int unsigned NBTN         = 21,
    parameter int unsigned CW           = 5,
    parameter int unsigned DEBOUNCE     = 2,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic            hz100,
    input  logic            reset,
    input  logic [NBTN-1:0] pb,
    output logic [CW-1:0]   code,
    output logic            strobe,
    output logic            held,
    output logic            multi
);

    localparam int unsigned CNTW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Reject configurations where the top index cannot be encoded or the counters cannot work.
    if (NBTN < 2 || NBTN > 32 || CW < $clog2(NBTN) || DEBOUNCE < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_check
        $error("pb_keycode_encoder: illegal parameter combination");
    end

    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] s;
    logic            any;
    logic            multi_hot;
    logic [CW-1:0]   idx;

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_d;
    logic [CW-1:0]   cand;
    logic [CW-1:0]   cand_d;
    logic [CW-1:0]   code_d;
    logic            strobe_d;
    logic            held_d;
    logic            multi_d;

`ifdef PB_ENC_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCW     = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    logic [RCW-1:0]  rcnt;
    logic [RCW-1:0]  rcnt_d;
    logic            rphase;
    logic            rphase_d;
`endif

    assign any       = |s;
    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi_hot = |(s & (s - NBTN'(1)));

    // Highest-index pressed button; zero when nothing is down.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < NBTN; i++) begin
            if (s[i]) begin
                idx = CW'(i);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cand_d   = cand;
        code_d   = code;
        strobe_d = 1'b0;
        held_d   = held;
        multi_d  = multi;
`ifdef PB_ENC_AUTOREPEAT_EN
        rcnt_d   = rcnt;
        rphase_d = rphase;
`endif
        case (state)
            ST_IDLE: begin
                held_d  = 1'b0;
                multi_d = 1'b0;
                if (any) begin
                    state_d = ST_DEBOUNCE;
                    cand_d  = idx;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!any) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (idx != cand) begin
                    cand_d = idx;
                    cnt_d  = '0;
                end else if (cnt == CNTW'(DEBOUNCE - 1)) begin
                    state_d  = ST_PRESSED;
                    code_d   = cand;
                    strobe_d = 1'b1;
                    held_d   = 1'b1;
                    multi_d  = multi_hot;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            ST_PRESSED: begin
                held_d  = 1'b1;
                multi_d = multi_hot;
                // A changed top index is a release, never a new press.
                if (!any || idx != code) begin
                    state_d = ST_RELEASE;
                    held_d  = 1'b0;
                    multi_d = 1'b0;
                    cnt_d   = '0;
`ifdef PB_ENC_AUTOREPEAT_EN
                    rcnt_d   = '0;
                    rphase_d = 1'b0;
                end else if (!rphase && rcnt == RCW'(REPEAT_DELAY - 1)) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                    rphase_d = 1'b1;
                end else if (rphase && rcnt == RCW'(REPEAT_RATE - 1)) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt + RCW'(1);
`endif
                end
            end
            ST_RELEASE: begin
                held_d  = 1'b0;
                multi_d = 1'b0;
                if (any) begin
                    cnt_d = '0;
                end else if (cnt == CNTW'(DEBOUNCE - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, synchroniser and output registers.
    always_ff @(posedge hz100) begin
        if (reset) begin
            sync1  <= '0;
            s      <= '0;
            state  <= ST_IDLE;
            cnt    <= '0;
            cand   <= '0;
            code   <= '0;
            strobe <= 1'b0;
            held   <= 1'b0;
            multi  <= 1'b0;
`ifdef PB_ENC_AUTOREPEAT_EN
            rcnt   <= '0;
            rphase <= 1'b0;
`endif
        end else begin
            sync1  <= pb;
            s      <= sync1;
            state  <= state_d;
            cnt    <= cnt_d;
            cand   <= cand_d;
            code   <= code_d;
            strobe <= strobe_d;
            held   <= held_d;
            multi  <= multi_d;
`ifdef PB_ENC_AUTOREPEAT_EN
            rcnt   <= rcnt_d;
            rphase <= rphase_d;
`endif
        end
    end

endmodule

// File: tb/tb_pb_keycode_encoder.sv
// Self-checking bench for pb_keycode_encoder: directed scenarios plus randomized press/gap traffic.
module tb_pb_keycode_encoder;

    localparam int unsigned NBTN = 21;
    localparam int unsigned CW   = 5;
    localparam int unsigned DB   = 2;
    localparam int unsigned RD   = 50;
    localparam int unsigned RR   = 10;
    // Edges from the edge after which pb rises until strobe is visible: two sync flops,
    // one IDLE cycle, DB debounce cycles.
    localparam int unsigned LAT  = DB + 3;
    localparam int unsigned NS   = 400;

    logic            hz100 = 1'b0;
    logic            reset;
    logic [NBTN-1:0] pb;
    logic [CW-1:0]   code;
    logic            strobe;
    logic            held;
    logic            multi;

    int checks   = 0;
    int failures = 0;

    logic [NBTN-1:0] sched [NS];
    bit              exp_s [NS];
    logic [CW-1:0]   exp_c [NS];

    pb_keycode_encoder #(
        .NBTN(NBTN), .CW(CW), .DEBOUNCE(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .hz100 (hz100),
        .reset (reset),
        .pb    (pb),
        .code  (code),
        .strobe(strobe),
        .held  (held),
        .multi (multi)
    );

    always #5 hz100 = ~hz100;

    task automatic step();
        @(posedge hz100);
        #1;
    endtask

    task automatic idle(input int n);
        pb = '0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        pb    = '0;
        step();
        step();
        checks += 4;
        if (code !== '0)    begin failures++; $display("FAIL reset_code: got %0d want 0", code); end
        if (strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b want 0", strobe); end
        if (held !== 1'b0)   begin failures++; $display("FAIL reset_held: got %b want 0", held); end
        if (multi !== 1'b0)  begin failures++; $display("FAIL reset_multi: got %b want 0", multi); end
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (strobe !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL idle_strobes: got %0d want 0", n); end
    endtask

    task automatic test_single_press();
        pb    = '0;
        pb[5] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (strobe !== (k == LAT)) begin
                failures++; $display("FAIL single_strobe k=%0d: got %b want %b", k, strobe, (k == LAT));
            end
            if (k == LAT) begin
                checks += 2;
                if (code !== CW'(5)) begin failures++; $display("FAIL single_code: got %0d want 5", code); end
                if (held !== 1'b1)   begin failures++; $display("FAIL single_held: got %b want 1", held); end
            end
        end
        pb = '0;
        repeat (3) step();
        checks++;
        if (held !== 1'b0) begin failures++; $display("FAIL single_release_held: got %b want 0", held); end
        idle(8);
    endtask

    task automatic test_bounce();
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            pb    = '0;
            pb[7] = (k % 2 == 0);
            step();
            if (strobe !== 1'b0) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL bounce_strobes: got %0d want 0", n); end
        pb    = '0;
        pb[7] = 1'b1;
        for (int k = 1; k <= LAT + 4; k++) begin
            step();
            checks++;
            if (strobe !== (k == LAT)) begin
                failures++; $display("FAIL bounce_strobe k=%0d: got %b want %b", k, strobe, (k == LAT));
            end
            if (k == LAT) begin
                checks++;
                if (code !== CW'(7)) begin failures++; $display("FAIL bounce_code: got %0d want 7", code); end
            end
        end
        idle(8);
    endtask

    task automatic test_multi();
        pb     = '0;
        pb[3]  = 1'b1;
        pb[12] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            checks++;
            if (strobe !== (k == LAT)) begin
                failures++; $display("FAIL multi_strobe k=%0d: got %b want %b", k, strobe, (k == LAT));
            end
            if (k == LAT) begin
                checks++;
                if (code !== CW'(12)) begin failures++; $display("FAIL multi_code: got %0d want 12", code); end
            end
        end
        checks += 2;
        if (multi !== 1'b1) begin failures++; $display("FAIL multi_flag: got %b want 1", multi); end
        if (held !== 1'b1)  begin failures++; $display("FAIL multi_held: got %b want 1", held); end
        pb[12] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (strobe !== 1'b0) begin failures++; $display("FAIL multi_drop_strobe k=%0d: got %b want 0", k, strobe); end
            if (k == 3 || k == 8) begin
                checks++;
                if (held !== 1'b0) begin failures++; $display("FAIL multi_drop_held k=%0d: got %b want 0", k, held); end
            end
        end
        idle(8);
    endtask

    task automatic test_reset_midpress();
        pb     = '0;
        pb[20] = 1'b1;
        repeat (LAT) step();
        checks++;
        if (strobe !== 1'b1) begin failures++; $display("FAIL midpress_first_strobe: got %b want 1", strobe); end
        repeat (3) step();
        reset = 1'b1;
        step();
        checks += 4;
        if (code !== '0)     begin failures++; $display("FAIL midpress_rst_code: got %0d want 0", code); end
        if (strobe !== 1'b0) begin failures++; $display("FAIL midpress_rst_strobe: got %b want 0", strobe); end
        if (held !== 1'b0)   begin failures++; $display("FAIL midpress_rst_held: got %b want 0", held); end
        if (multi !== 1'b0)  begin failures++; $display("FAIL midpress_rst_multi: got %b want 0", multi); end
        reset = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            checks++;
            if (strobe !== (k == LAT)) begin
                failures++; $display("FAIL midpress_strobe k=%0d: got %b want %b", k, strobe, (k == LAT));
            end
            if (k == LAT) begin
                checks += 2;
                if (code !== CW'(20)) begin failures++; $display("FAIL midpress_code: got %0d want 20", code); end
                if (held !== 1'b1)    begin failures++; $display("FAIL midpress_held: got %b want 1", held); end
            end
        end
        idle(8);
    endtask

    task automatic test_autorepeat();
        bit e;
        pb    = '0;
        pb[1] = 1'b1;
        for (int k = 1; k <= 104; k++) begin
            if (k == 101) pb = '0;
            step();
            e = (k == LAT);
`ifdef PB_ENC_AUTOREPEAT_EN
            // Repeats at accept+RD, then every RR while the button is still seen down.
            if (k >= LAT + RD && k <= 100 && ((k - LAT - RD) % RR) == 0) e = 1'b1;
`endif
            checks++;
            if (strobe !== e) begin
                failures++; $display("FAIL repeat_strobe k=%0d: got %b want %b", k, strobe, e);
            end
            if (e) begin
                checks++;
                if (code !== CW'(1)) begin failures++; $display("FAIL repeat_code k=%0d: got %0d want 1", k, code); end
            end
        end
        idle(8);
    endtask

    // Random single or chorded presses separated by gaps long enough for a full release.
    task automatic test_random();
        int t;
        int len;
        int gap;
        int hi;
        int lo;
        for (int i = 0; i < NS; i++) begin
            sched[i] = '0;
            exp_s[i] = 1'b0;
            exp_c[i] = '0;
        end
        t = 0;
        while (t + 8 + 6 + LAT < NS) begin
            len = $urandom_range(7, 1);
            gap = $urandom_range(6, DB + 1);
            hi  = $urandom_range(NBTN - 1, 0);
            for (int j = t; j < t + len; j++) sched[j][hi] = 1'b1;
            if (hi > 0 && $urandom_range(3, 0) == 0) begin
                lo = $urandom_range(hi - 1, 0);
                for (int j = t; j < t + len; j++) sched[j][lo] = 1'b1;
            end
            if (len >= DB + 1) begin
                exp_s[t + LAT - 1] = 1'b1;
                exp_c[t + LAT - 1] = CW'(hi);
            end
            t += len + gap;
        end
        for (int i = 0; i < NS; i++) begin
            pb = sched[i];
            step();
            checks++;
            if (strobe !== exp_s[i]) begin
                failures++; $display("FAIL rand_strobe t=%0d: got %b want %b", i, strobe, exp_s[i]);
            end
            if (exp_s[i]) begin
                checks++;
                if (code !== exp_c[i]) begin
                    failures++; $display("FAIL rand_code t=%0d: got %0d want %0d", i, code, exp_c[i]);
                end
            end
        end
        idle(8);
    endtask

    initial begin
        reset = 1'b1;
        pb    = '0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi();
        test_reset_midpress();
        test_autorepeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
